// File: rtl/tausworthe_multi.sv
// tausworthe_multi: LANES independent combined Tausworthe (taus88) generators.
// Each lane keeps three 32-bit state words and produces one 32-bit sample per
// transfer on a valid/ready interface. Seeds are loaded at runtime as 3*LANES
// words, and a warm-up phase discards WARMUP state advances before output.
// Optional build macro TAUS_SAMPLE_CNT_EN adds the sample_cnt transfer counter.
module tausworthe_multi #(
    parameter int LANES  = 2,
    parameter int WARMUP = 0,
    parameter int CNT_W  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  seed_valid,
    input  logic [31:0]           seed_data,
    output logic                  seed_ready,
    output logic [32*LANES-1:0]   random_out,
    output logic                  valid_out,
    input  logic                  ready_in
`ifdef TAUS_SAMPLE_CNT_EN
    ,
    output logic [CNT_W-1:0]      sample_cnt
`endif
);

    localparam int NW    = 3 * LANES;
    localparam int IDX_W = $clog2(NW + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NW - 1);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
    localparam logic [15:0]      WARM_INIT = 16'(WARMUP);

    localparam logic [1:0] ST_WARM = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    if (LANES < 1 || CNT_W < 1 || WARMUP < 0 || WARMUP > 65535) begin : g_bad_param
        $error("tausworthe_multi: illegal parameter value");
    end

    // Smallest legal value of state word r (low bits must leave the recurrence alive).
    function automatic logic [31:0] word_min(input int r);
        case (r)
            0:       return 32'd2;
            1:       return 32'd8;
            default: return 32'd16;
        endcase
    endfunction

    // Default state word r of a lane: legacy constant xored with a golden-ratio lane key.
    function automatic logic [31:0] word_default(input int lane, input int r);
        logic [31:0] k;
        logic [31:0] base;
        logic [31:0] d;
        k = 32'(lane) * 32'h9E37_79B9;
        case (r)
            0:       base = 32'hF0F0_F0F0;
            1:       base = 32'hC0C0_C0C0;
            default: base = 32'hFF00_FF00;
        endcase
        d = base ^ k;
        if (d < word_min(r)) begin
            d = d | 32'h0000_0010;
        end
        return d;
    endfunction

    // Replace a degenerate seed word with the register default.
    function automatic logic [31:0] legalize(input logic [31:0] v, input int lane, input int r);
        return (v < word_min(r)) ? word_default(lane, r) : v;
    endfunction

    // One taus88 recurrence step of state word r.
    function automatic logic [31:0] step_word(input logic [31:0] v, input int r);
        logic [31:0] b;
        case (r)
            0: begin
                b = ((v << 13) ^ v) >> 19;
                return ((v & 32'hFFFF_FFFE) << 12) ^ b;
            end
            1: begin
                b = ((v << 2) ^ v) >> 25;
                return ((v & 32'hFFFF_FFF8) << 4) ^ b;
            end
            default: begin
                b = ((v << 3) ^ v) >> 11;
                return ((v & 32'hFFFF_FFF0) << 17) ^ b;
            end
        endcase
    endfunction

    logic [NW-1:0][31:0]    st_q, st_d;
    logic [NW-1:0][31:0]    stepped_s;
    logic [32*LANES-1:0]    sample_s;
    logic [32*LANES-1:0]    out_q, out_d;
    logic                   valid_q, valid_d;
    logic [1:0]             state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   seed_ready_q;
    logic                   seed_first_s;

    // Next state of every word and the per-lane sample of the current state.
    always_comb begin
        stepped_s = st_q;
        sample_s  = {(32*LANES){1'b0}};
        for (int w = 0; w < NW; w++) begin
            stepped_s[w] = step_word(st_q[w], w % 3);
        end
        for (int l = 0; l < LANES; l++) begin
            sample_s[32*l +: 32] = st_q[3*l] ^ st_q[3*l+1] ^ st_q[3*l+2];
        end
    end

    // Control: warm-up counting, output handshake and seed word sequencing.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        st_d         = st_q;
        out_d        = out_q;
        valid_d      = valid_q;
        seed_first_s = 1'b0;
        case (state_q)
            ST_WARM: begin
                if (cnt_q != 16'd0) begin
                    st_d  = stepped_s;
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Load when the output is empty or being consumed; hold while stalled.
                if (!valid_q || ready_in) begin
                    out_d   = sample_s;
                    valid_d = 1'b1;
                    st_d    = stepped_s;
                end else begin
                    out_d = out_q;
                end
            end
            ST_LOAD: begin
                if (seed_valid) begin
                    for (int w = 0; w < NW; w++) begin
                        st_d[w] = (IDX_W'(w) == idx_q) ? legalize(seed_data, w / 3, w % 3) : st_q[w];
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = {IDX_W{1'b0}};
                        cnt_d   = WARM_INIT;
                        state_d = ST_WARM;
                    end else begin
                        idx_d = idx_q + FIRST_IDX;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = ST_WARM;
            end
        endcase
        // The first seed word preempts whatever the current state would do:
        // no stepping, output invalidated, word 0 written.
        if (seed_valid && (state_q != ST_LOAD)) begin
            st_d         = st_q;
            st_d[0]      = legalize(seed_data, 0, 0);
            idx_d        = FIRST_IDX;
            valid_d      = 1'b0;
            out_d        = out_q;
            state_d      = ST_LOAD;
            seed_first_s = 1'b1;
        end else begin
            seed_first_s = 1'b0;
        end
    end

    // State, output and control registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_WARM;
            cnt_q        <= WARM_INIT;
            idx_q        <= {IDX_W{1'b0}};
            out_q        <= {(32*LANES){1'b0}};
            valid_q      <= 1'b0;
            seed_ready_q <= 1'b1;
            for (int w = 0; w < NW; w++) begin
                st_q[w] <= word_default(w / 3, w % 3);
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            out_q        <= out_d;
            valid_q      <= valid_d;
            seed_ready_q <= 1'b1;
            st_q         <= st_d;
        end
    end

    assign random_out = out_q;
    assign valid_out  = valid_q;
    assign seed_ready = seed_ready_q;

`ifdef TAUS_SAMPLE_CNT_EN
    logic [CNT_W-1:0] smp_q, smp_d;

    // Saturating transfer count, cleared when a new seed starts.
    always_comb begin
        smp_d = smp_q;
        if (seed_first_s) begin
            smp_d = {CNT_W{1'b0}};
        end else if (valid_q && ready_in && (smp_q != {CNT_W{1'b1}})) begin
            smp_d = smp_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            smp_d = smp_q;
        end
    end

    // Sample counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            smp_q <= {CNT_W{1'b0}};
        end else begin
            smp_q <= smp_d;
        end
    end

    assign sample_cnt = smp_q;
`endif

endmodule

// File: tb/tb_tausworthe_multi.sv
// Self-checking bench for tausworthe_multi: a 2-lane, WARMUP=0 instance driven
// with seeds and random backpressure, plus a 1-lane, WARMUP=3 instance that
// free-runs on the legacy defaults. Both are compared to a behavioural model.
module tb_tausworthe_multi;

    localparam int LANES = 2;
    localparam int NW    = 3 * LANES;

    logic                clock;
    logic                reset;
    logic                seed_valid;
    logic [31:0]         seed_data;
    logic                seed_ready;
    logic [32*LANES-1:0] random_out;
    logic                valid_out;
    logic                ready_in;
    logic [31:0]         u1_random;
    logic                u1_valid;
    logic                u1_seed_ready;
`ifdef TAUS_SAMPLE_CNT_EN
    logic [3:0]          sample_cnt;
    logic [3:0]          u1_sample_cnt;
`endif

    tausworthe_multi #(.LANES(LANES), .WARMUP(0), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .seed_valid(seed_valid), .seed_data(seed_data),
        .seed_ready(seed_ready), .random_out(random_out), .valid_out(valid_out),
        .ready_in(ready_in)
`ifdef TAUS_SAMPLE_CNT_EN
        , .sample_cnt(sample_cnt)
`endif
    );

    tausworthe_multi #(.LANES(1), .WARMUP(3), .CNT_W(4)) u1 (
        .clock(clock), .reset(reset), .seed_valid(1'b0), .seed_data(32'd0),
        .seed_ready(u1_seed_ready), .random_out(u1_random), .valid_out(u1_valid),
        .ready_in(1'b1)
`ifdef TAUS_SAMPLE_CNT_EN
        , .sample_cnt(u1_sample_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests;
    int n_fail;
    int exp_cnt;
    int unsigned m_s [LANES][3];
    int unsigned m1_s [3];

    // ---------------- behavioural model ----------------
    function automatic int unsigned m_lim(input int r);
        return (r == 0) ? 32'd2 : ((r == 1) ? 32'd8 : 32'd16);
    endfunction

    function automatic int unsigned m_def(input int lane, input int r);
        int unsigned base;
        int unsigned d;
        base = (r == 0) ? 32'hF0F0F0F0 : ((r == 1) ? 32'hC0C0C0C0 : 32'hFF00FF00);
        d = base ^ (int'(lane) * 32'd2654435769);
        if (d < m_lim(r)) d = d | 32'd16;
        return d;
    endfunction

    function automatic int unsigned m_fix(input int unsigned v, input int lane, input int r);
        return (v < m_lim(r)) ? m_def(lane, r) : v;
    endfunction

    // taus88 recurrence written with modular multiply/divide.
    function automatic int unsigned m_step(input int unsigned v, input int r);
        int unsigned b;
        if (r == 0) begin
            b = ((v * 32'd8192) ^ v) / 32'd524288;
            return ((v & ~32'd1) * 32'd4096) ^ b;
        end else if (r == 1) begin
            b = ((v * 32'd4) ^ v) / 32'd33554432;
            return ((v & ~32'd7) * 32'd16) ^ b;
        end else begin
            b = ((v * 32'd8) ^ v) / 32'd2048;
            return ((v & ~32'd15) * 32'd131072) ^ b;
        end
    endfunction

    function automatic logic [63:0] m_word();
        logic [63:0] x;
        for (int l = 0; l < LANES; l++) x[32*l +: 32] = m_s[l][0] ^ m_s[l][1] ^ m_s[l][2];
        return x;
    endfunction

    task automatic m_adv();
        for (int l = 0; l < LANES; l++)
            for (int r = 0; r < 3; r++) m_s[l][r] = m_step(m_s[l][r], r);
    endtask

    task automatic m1_adv();
        for (int r = 0; r < 3; r++) m1_s[r] = m_step(m1_s[r], r);
    endtask

    task automatic m_reset();
        for (int l = 0; l < LANES; l++)
            for (int r = 0; r < 3; r++) m_s[l][r] = m_def(l, r);
        for (int r = 0; r < 3; r++) m1_s[r] = m_def(0, r);
        for (int i = 0; i < 3; i++) m1_adv();
        exp_cnt = 0;
    endtask

    function automatic logic [63:0] first_of(input logic [31:0] w [NW]);
        logic [63:0] x;
        for (int l = 0; l < LANES; l++)
            x[32*l +: 32] = m_fix(w[3*l], l, 0) ^ m_fix(w[3*l+1], l, 1) ^ m_fix(w[3*l+2], l, 2);
        return x;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: score transfers seen before the edge, then check holds after it.
    task automatic cyc(input bit seed_first);
        bit          stall;
        bit          sv;
        logic [63:0] held;
        stall = valid_out && !ready_in;
        sv    = seed_valid;
        held  = random_out;
        if (valid_out && ready_in) begin
            chk("xfer", random_out, m_word());
            m_adv();
            if (exp_cnt < 15) exp_cnt++;
        end
        if (u1_valid) begin
            chk("u1_xfer", 64'(u1_random), 64'(m1_s[0] ^ m1_s[1] ^ m1_s[2]));
            m1_adv();
        end
        if (seed_first) exp_cnt = 0;
        @(posedge clock);
        #1;
        if (stall && !sv) begin
            chk("hold_valid", 64'(valid_out), 64'd1);
            chk("hold_data", random_out, held);
        end
`ifdef TAUS_SAMPLE_CNT_EN
        chk("sample_cnt", 64'(sample_cnt), 64'(exp_cnt));
`endif
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        seed_valid = 1'b0;
        seed_data  = 32'd0;
        ready_in   = 1'b1;
        #2;
        chk("rst_random", random_out, 64'd0);
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_seed_ready", 64'(seed_ready), 64'd1);
        chk("rst_u1_valid", 64'(u1_valid), 64'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        m_reset();
        for (int c = 1; c <= 6; c++) begin
            cyc(1'b0);
            if (c == 1) chk("lat_c1_valid", 64'(valid_out), 64'd0);
            if (c == 2) begin
                chk("lat_c2_valid", 64'(valid_out), 64'd1);
                chk("legacy_first", 64'(random_out[31:0]), 64'h00000000CF30CF30);
            end
            if (c == 4) chk("u1_lat_c4", 64'(u1_valid), 64'd0);
            if (c == 5) chk("u1_lat_c5", 64'(u1_valid), 64'd1);
        end
        chk("seed_ready_run", 64'(seed_ready), 64'd1);
    endtask

    task automatic load_seed(input logic [31:0] w [NW]);
        for (int i = 0; i < NW; i++) begin
            seed_valid = 1'b1;
            seed_data  = w[i];
            cyc(i == 0);
            if (i == 0) chk("seed_drop_valid", 64'(valid_out), 64'd0);
        end
        seed_valid = 1'b0;
        seed_data  = 32'd0;
        for (int l = 0; l < LANES; l++)
            for (int r = 0; r < 3; r++) m_s[l][r] = m_fix(w[3*l+r], l, r);
        cyc(1'b0);
        chk("seed_lat1_valid", 64'(valid_out), 64'd0);
        cyc(1'b0);
        chk("seed_lat2_valid", 64'(valid_out), 64'd1);
    endtask

    typedef struct {
        logic [31:0] w [NW];
        int          n_cycles;
        logic [63:0] first;
    } vec_t;

    vec_t vt [4];

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        exp_cnt    = 0;
        reset      = 1'b1;
        seed_valid = 1'b0;
        seed_data  = 32'd0;
        ready_in   = 1'b0;

        vt[0].w = '{32'd1, 32'd5, 32'd3, 32'd0, 32'd1, 32'd2};
        vt[0].first = 64'h5107B689_CF30CF30;
        vt[0].n_cycles = 40;
        vt[1].w = '{32'd12345, 32'd67890, 32'd54321, 32'hDEADBEEF, 32'h12345678, 32'hCAFEBABE};
        vt[1].first = first_of(vt[1].w);
        vt[1].n_cycles = 60;
        vt[2].w = '{32'd2, 32'd8, 32'd16, 32'hFFFFFFFF, 32'd7, 32'd15};
        vt[2].first = 64'hC03FC03F_0000001A;
        vt[2].n_cycles = 40;
        for (int i = 0; i < NW; i++) vt[3].w[i] = $urandom;
        vt[3].first = first_of(vt[3].w);
        vt[3].n_cycles = 60;

        do_reset();

        // Saturation of the transfer counter with continuous consumption.
        ready_in = 1'b1;
        for (int i = 0; i < 20; i++) cyc(1'b0);

        // Stall for five cycles, then resume without skip or duplicate.
        ready_in = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b0);
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0);

        // Seed table; ready is high at each seed start so a transfer coincides with word 0.
        for (int v = 0; v < 4; v++) begin
            ready_in = 1'b1;
            load_seed(vt[v].w);
            chk("seed_first", random_out, vt[v].first);
            for (int i = 0; i < vt[v].n_cycles; i++) begin
                ready_in = 1'($urandom_range(0, 1));
                cyc(1'b0);
            end
        end

        // Reset after two of the six seed words: defaults resume.
        ready_in   = 1'b1;
        seed_valid = 1'b1;
        seed_data  = 32'd12345;
        cyc(1'b1);
        seed_data  = 32'd67890;
        cyc(1'b0);
        do_reset();

        // Long run with random backpressure; the 1-lane instance free-runs alongside.
        for (int i = 0; i < 1000; i++) begin
            ready_in = 1'($urandom_range(0, 3) != 0);
            cyc(1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
